ifid_stall_pipe: RTL

//  Responder side of the load-use stall handshake: owns PC, IF/ID register and ID/EX control

---
 rtl/ifid_stall_pipe_pkg.sv | 16 +
 rtl/ifid_stall_pipe_if.sv | 42 ++++
 rtl/ifid_stall_pipe_pipe_reg.sv | 19 +
 rtl/ifid_stall_pipe.sv | 102 ++++++++++
 4 files changed

// File: rtl/ifid_stall_pipe_pkg.sv
// Shared types and defaults for the IF/ID stall-handshake slice.
// Optional perf counters in the top are enabled by STALL_PERF_CNT_EN.
package ifid_stall_pipe_pkg;

    localparam logic [31:0]  RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0]  NOP_INSTR    = 32'h0000_0000;
    localparam int unsigned  CTRL_W_DEF   = 10;
    localparam int unsigned  RUN_CNT_W    = 3;

    typedef enum logic {RUN, STALL} pipe_state_t;

    function automatic logic [31:0] pc_inc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/ifid_stall_pipe_if.sv
// Stall-control / fetch / decode signal bundle for ifid_stall_pipe.
// Perf counter outputs exist only when STALL_PERF_CNT_EN is defined.
interface ifid_stall_pipe_if #(parameter int unsigned CTRL_W = 10);

    logic              PC_WriteEn;
    logic              IFID_WriteEn;
    logic              Stall_flush;
    logic              branch_taken;
    logic [31:0]       branch_target;
    logic [31:0]       imem_instr;
    logic [CTRL_W-1:0] id_ctrl;
    logic [31:0]       pc;
    logic [31:0]       ifid_instr;
    logic [31:0]       ifid_pc4;
    logic              ifid_valid;
    logic [CTRL_W-1:0] idex_ctrl;
    logic              stalled;
    logic              stall_timeout;
`ifdef STALL_PERF_CNT_EN
    logic [31:0]       stall_cycles;
    logic [15:0]       stall_events;
`endif

    modport master (
        output PC_WriteEn, IFID_WriteEn, Stall_flush, branch_taken, branch_target,
        output imem_instr, id_ctrl,
`ifdef STALL_PERF_CNT_EN
        input  stall_cycles, stall_events,
`endif
        input  pc, ifid_instr, ifid_pc4, ifid_valid, idex_ctrl, stalled, stall_timeout
    );

    modport slave (
        input  PC_WriteEn, IFID_WriteEn, Stall_flush, branch_taken, branch_target,
        input  imem_instr, id_ctrl,
`ifdef STALL_PERF_CNT_EN
        output stall_cycles, stall_events,
`endif
        output pc, ifid_instr, ifid_pc4, ifid_valid, idex_ctrl, stalled, stall_timeout
    );

endinterface

// File: rtl/ifid_stall_pipe_pipe_reg.sv
// Width-parameterised pipeline register with load enable and synchronous clear.
module pipe_reg #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Clear wins over enable so a flush/bubble is never masked by a hold.
    always_ff @(posedge clk) begin
        if (reset || clr) q <= '0;
        else if (en)      q <= d;
    end

endmodule

// File: rtl/ifid_stall_pipe.sv
// PC, IF/ID and ID/EX bubble owner for the load-use stall handshake.
// Define STALL_PERF_CNT_EN to add stall_cycles / stall_events counters.
module ifid_stall_pipe
    import ifid_stall_pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
    parameter int unsigned CTRL_W    = CTRL_W_DEF,
    parameter int unsigned MAX_STALL = 4
) (
    input  logic               clk,
    input  logic               reset,
    ifid_stall_pipe_if.slave   bus
);

    localparam int unsigned          LIM       = (MAX_STALL > 7) ? 7 : MAX_STALL;
    localparam logic [RUN_CNT_W-1:0] RUN_LIMIT = RUN_CNT_W'(LIM);
    localparam logic [RUN_CNT_W-1:0] RUN_SAT   = '1;

    pipe_state_t          state_q, state_d;
    logic [31:0]          pc_q, pc_d, pc_plus4;
    logic [RUN_CNT_W-1:0] run_cnt_q, run_cnt_d;
    logic                 timeout_q, timeout_d;
    logic [64:0]          ifid_q;

    assign pc_plus4 = pc_inc(pc_q);

    always_comb begin
        state_d   = bus.Stall_flush ? STALL : RUN;
        run_cnt_d = '0;
        timeout_d = timeout_q;
        pc_d      = pc_q;
        // Run length counts every flush cycle, including the RUN->STALL entry cycle.
        if (bus.Stall_flush) begin
            run_cnt_d = (run_cnt_q == RUN_SAT) ? RUN_SAT : run_cnt_q + 1'b1;
            if (run_cnt_d >= RUN_LIMIT) timeout_d = 1'b1;
            if (bus.PC_WriteEn) pc_d = pc_plus4;
        end else if (bus.branch_taken) begin
            pc_d = bus.branch_target;
        end else if (bus.PC_WriteEn) begin
            pc_d = pc_plus4;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= RUN;
            pc_q      <= RESET_PC;
            run_cnt_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            run_cnt_q <= run_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    // IF/ID packs {valid, pc4, instr}; a taken branch outside a stall clears it to a NOP.
    pipe_reg #(.W(65)) u_ifid (
        .clk   (clk),
        .reset (reset),
        .en    (bus.IFID_WriteEn),
        .clr   (!bus.Stall_flush && bus.branch_taken),
        .d     ({1'b1, pc_plus4, bus.imem_instr}),
        .q     (ifid_q)
    );

    pipe_reg #(.W(CTRL_W)) u_idex (
        .clk   (clk),
        .reset (reset),
        .en    (1'b1),
        .clr   (bus.Stall_flush),
        .d     (bus.id_ctrl),
        .q     (bus.idex_ctrl)
    );

    assign bus.pc            = pc_q;
    assign bus.ifid_valid    = ifid_q[64];
    assign bus.ifid_pc4      = ifid_q[63:32];
    assign bus.ifid_instr    = ifid_q[64] ? ifid_q[31:0] : NOP_INSTR;
    assign bus.stalled       = (state_q == STALL);
    assign bus.stall_timeout = timeout_q;

`ifdef STALL_PERF_CNT_EN
    logic [31:0] stall_cycles_q;
    logic [15:0] stall_events_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles_q <= '0;
            stall_events_q <= '0;
        end else if (bus.Stall_flush) begin
            stall_cycles_q <= stall_cycles_q + 32'd1;
            if (state_q == RUN) stall_events_q <= stall_events_q + 16'd1;
        end
    end

    assign bus.stall_cycles = stall_cycles_q;
    assign bus.stall_events = stall_events_q;
`endif

endmodule
